vdp_cmd_ctrl: RTL and testbench

Downstream of the VDP port block. Consumes completed two-byte control-port commands and individual data-port accesses, and turns them into VRAM, CRAM and VDP register operations. Owns the 14-bit address register, the 2-bit access code, the read-ahead buffer and a single-outstanding VRAM request handshake. Feeds the VRAM arbiter and the register file / CRAM used by the display pipeline.

---
 rtl/vdp_cmd_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_vdp_cmd_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vdp_cmd_ctrl : VDP command/data-port controller (VRAM, CRAM, registers).   |
// | Optional VDP_CMD_STATS_EN enables the saturating drop_cnt counter.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vdp_cmd_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int CRAM_AW = 5,
  parameter int NREG_W  = 4
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               cmd_valid,
  input  logic [15:0]        cmd_word,
  input  logic               dwr_valid,
  input  logic [7:0]         dwr_byte,
  input  logic               drd_valid,
  output logic [7:0]         rd_buf,
  output logic               busy,
  output logic               vram_req,
  output logic               vram_we,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic               vram_ack,
  input  logic [7:0]         vram_rdata,
  output logic               cram_we,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [7:0]         cram_wdata,
  output logic               reg_we,
  output logic [NREG_W-1:0]  reg_idx,
  output logic [7:0]         reg_wdata,
  output logic               overrun,
  output logic [7:0]         drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_FETCH = 2'd1,
    S_WR_STORE = 2'd2
  } state_t;

  localparam logic [1:0]        c_ev_none = 2'd0;
  localparam logic [1:0]        c_ev_cmd  = 2'd1;
  localparam logic [1:0]        c_ev_dwr  = 2'd2;
  localparam logic [1:0]        c_ev_drd  = 2'd3;
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_code;
  logic [7:0]          r_rd_buf;
  logic                r_pend_valid;
  logic [1:0]          r_pend_type;
  logic [15:0]         r_pend_data;
  logic                r_vram_req;
  logic                r_vram_we;
  logic [ADDR_W-1:0]   r_vram_addr;
  logic [7:0]          r_vram_wdata;
  logic                r_cram_we;
  logic [CRAM_AW-1:0]  r_cram_addr;
  logic [7:0]          r_cram_wdata;
  logic                r_reg_we;
  logic [NREG_W-1:0]   r_reg_idx;
  logic [7:0]          r_reg_wdata;
  logic                r_overrun;

  logic [1:0]          w_in_type;
  logic [15:0]         w_in_data;
  logic [1:0]          w_lower_drops;
  logic                w_idle;
  logic                w_slot_full;
  logic                w_in_dropped;
  logic                w_to_slot;
  logic                w_exec_pend;
  logic [1:0]          w_exec_type;
  logic [15:0]         w_exec_data;
  logic [1:0]          w_drops;
  logic [ADDR_W-1:0]   w_cmd_addr;
  logic [ADDR_W-1:0]   w_addr_inc;

  // Priority select: cmd > dwr > drd; losing strobes are counted as drops.
  always_comb begin
    w_in_type     = c_ev_none;
    w_in_data     = 16'h0000;
    w_lower_drops = 2'd0;
    if (cmd_valid) begin
      w_in_type     = c_ev_cmd;
      w_in_data     = cmd_word;
      w_lower_drops = {1'b0, dwr_valid} + {1'b0, drd_valid};
    end else if (dwr_valid) begin
      w_in_type     = c_ev_dwr;
      w_in_data     = {8'h00, dwr_byte};
      w_lower_drops = {1'b0, drd_valid};
    end else if (drd_valid) begin
      w_in_type     = c_ev_drd;
    end
  end

  assign w_idle       = (r_state == S_IDLE);
  assign w_slot_full  = !w_idle && r_pend_valid;
  assign w_exec_pend  = w_idle && r_pend_valid;
  assign w_in_dropped = (w_in_type != c_ev_none) && w_slot_full;
  // A held event runs first; a fresh event arriving in that same cycle takes its place.
  assign w_to_slot    = (w_in_type != c_ev_none) && !w_slot_full && !(w_idle && !r_pend_valid);
  assign w_exec_type  = w_exec_pend ? r_pend_type : (w_idle ? w_in_type : c_ev_none);
  assign w_exec_data  = w_exec_pend ? r_pend_data : w_in_data;
  assign w_drops      = w_lower_drops + {1'b0, w_in_dropped};
  assign w_cmd_addr   = ADDR_W'({w_exec_data[5:0], w_exec_data[15:8]});
  assign w_addr_inc   = r_addr + c_addr_one;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_code       <= 2'd0;
      r_rd_buf     <= 8'h00;
      r_pend_valid <= 1'b0;
      r_pend_type  <= c_ev_none;
      r_pend_data  <= 16'h0000;
      r_vram_req   <= 1'b0;
      r_vram_we    <= 1'b0;
      r_vram_addr  <= '0;
      r_vram_wdata <= 8'h00;
      r_cram_we    <= 1'b0;
      r_cram_addr  <= '0;
      r_cram_wdata <= 8'h00;
      r_reg_we     <= 1'b0;
      r_reg_idx    <= '0;
      r_reg_wdata  <= 8'h00;
      r_overrun    <= 1'b0;
    end else begin
      r_reg_we  <= 1'b0;
      r_cram_we <= 1'b0;
      if (w_drops != 2'd0) r_overrun <= 1'b1;

      if (w_to_slot) begin
        r_pend_valid <= 1'b1;
        r_pend_type  <= w_in_type;
        r_pend_data  <= w_in_data;
      end else if (w_exec_pend) begin
        r_pend_valid <= 1'b0;
      end

      case (r_state)
        S_RD_FETCH: begin
          if (vram_ack) begin
            r_rd_buf   <= vram_rdata;
            r_addr     <= w_addr_inc;
            r_vram_req <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_WR_STORE: begin
          if (vram_ack) begin
            r_addr     <= w_addr_inc;
            r_vram_req <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          case (w_exec_type)
            c_ev_cmd: begin
              r_code <= w_exec_data[7:6];
              r_addr <= w_cmd_addr;
              if (w_exec_data[7:6] == 2'd0) begin
                r_state     <= S_RD_FETCH;
                r_vram_req  <= 1'b1;
                r_vram_we   <= 1'b0;
                r_vram_addr <= w_cmd_addr;
              end else if (w_exec_data[7:6] == 2'd2) begin
                r_reg_we    <= 1'b1;
                r_reg_idx   <= w_exec_data[NREG_W-1:0];
                r_reg_wdata <= w_exec_data[15:8];
              end
            end
            c_ev_dwr: begin
              r_rd_buf <= w_exec_data[7:0];
              if (r_code == 2'd3) begin
                r_cram_we    <= 1'b1;
                r_cram_addr  <= r_addr[CRAM_AW-1:0];
                r_cram_wdata <= w_exec_data[7:0];
                r_addr       <= w_addr_inc;
              end else begin
                r_state      <= S_WR_STORE;
                r_vram_req   <= 1'b1;
                r_vram_we    <= 1'b1;
                r_vram_addr  <= r_addr;
                r_vram_wdata <= w_exec_data[7:0];
              end
            end
            c_ev_drd: begin
              r_state     <= S_RD_FETCH;
              r_vram_req  <= 1'b1;
              r_vram_we   <= 1'b0;
              r_vram_addr <= r_addr;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

`ifdef VDP_CMD_STATS_EN
  logic [7:0] r_drop_cnt;
  logic [8:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drops};

  always_ff @(posedge clk) begin
    if (!reset_L)          r_drop_cnt <= 8'h00;
    else if (w_drop_sum[8]) r_drop_cnt <= 8'hFF;
    else                   r_drop_cnt <= w_drop_sum[7:0];
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 8'h00;
`endif

  assign busy       = !w_idle || r_pend_valid;
  assign rd_buf     = r_rd_buf;
  assign vram_req   = r_vram_req;
  assign vram_we    = r_vram_we;
  assign vram_addr  = r_vram_addr;
  assign vram_wdata = r_vram_wdata;
  assign cram_we    = r_cram_we;
  assign cram_addr  = r_cram_addr;
  assign cram_wdata = r_cram_wdata;
  assign reg_we     = r_reg_we;
  assign reg_idx    = r_reg_idx;
  assign reg_wdata  = r_reg_wdata;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vdp_cmd_ctrl.sv
`default_nettype none
// Bench for vdp_cmd_ctrl: directed scenarios plus random traffic checked against
// a functional VDP port model (address/code/read-buffer semantics over arrays).
module tb_vdp_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_word = 16'h0000;
  logic        dwr_valid = 1'b0;
  logic [7:0]  dwr_byte = 8'h00;
  logic        drd_valid = 1'b0;
  logic [7:0]  rd_buf;
  logic        busy;
  logic        vram_req;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_ack = 1'b0;
  logic [7:0]  vram_rdata = 8'h00;
  logic        cram_we;
  logic [4:0]  cram_addr;
  logic [7:0]  cram_wdata;
  logic        reg_we;
  logic [3:0]  reg_idx;
  logic [7:0]  reg_wdata;
  logic        overrun;
  logic [7:0]  drop_cnt;

  vdp_cmd_ctrl #(.ADDR_W(14), .CRAM_AW(5), .NREG_W(4)) dut (
    .clk(clk), .reset_L(reset_L),
    .cmd_valid(cmd_valid), .cmd_word(cmd_word),
    .dwr_valid(dwr_valid), .dwr_byte(dwr_byte), .drd_valid(drd_valid),
    .rd_buf(rd_buf), .busy(busy),
    .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
    .cram_we(cram_we), .cram_addr(cram_addr), .cram_wdata(cram_wdata),
    .reg_we(reg_we), .reg_idx(reg_idx), .reg_wdata(reg_wdata),
    .overrun(overrun), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] mem     [0:16383];
  logic [7:0] ref_mem [0:16383];
  logic [7:0] dut_cram [0:31];
  logic [7:0] m_cram   [0:31];
  logic [7:0] dut_regs [0:15];
  logic [7:0] m_regs   [0:15];

  int   lat_mode = -1;
  int   lat_cnt  = 0;
  logic ack_hold = 1'b0;
  logic force_ack = 1'b0;

  // VRAM responder: acks after a programmable latency, memory updated on the ack.
  always @(negedge clk) begin
    vram_ack = force_ack;
    if (force_ack) vram_rdata = 8'hE7;
    if (vram_req === 1'b1 && !ack_hold) begin
      if (lat_cnt <= 0) begin
        vram_ack   = 1'b1;
        vram_rdata = mem[vram_addr];
        if (vram_we) mem[vram_addr] = vram_wdata;
        lat_cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end else begin
        lat_cnt--;
      end
    end
  end

  always @(negedge clk) begin
    if (reg_we === 1'b1)  dut_regs[reg_idx]  = reg_wdata;
    if (cram_we === 1'b1) dut_cram[cram_addr] = cram_wdata;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_cmd(input logic [15:0] w);
    cmd_word = w; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
  endtask

  task automatic pulse_dwr(input logic [7:0] b);
    dwr_byte = b; dwr_valid = 1'b1; step(); dwr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 100) begin step(); k++; end
    if (busy !== 1'b0) begin
      n_total++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, k);
    end
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; dwr_valid = 1'b0; drd_valid = 1'b0;
    reset_L = 1'b0; step(); step(); reset_L = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if ({busy, vram_req, vram_we, cram_we, reg_we, overrun} !== 6'b0) $display("FAIL reset_flags: got %b want 000000", {busy, vram_req, vram_we, cram_we, reg_we, overrun}); else n_pass++;
    n_total++; if (rd_buf !== 8'h00) $display("FAIL reset_rd_buf: got %h want 00", rd_buf); else n_pass++;
    n_total++; if (drop_cnt !== 8'h00) $display("FAIL reset_drop_cnt: got %h want 00", drop_cnt); else n_pass++;
    n_total++; if (vram_addr !== 14'h0) $display("FAIL reset_vram_addr: got %h want 0000", vram_addr); else n_pass++;
  endtask

  task automatic test_reg_write();
    pulse_cmd(16'h2281);
    n_total++; if (reg_we !== 1'b1) $display("FAIL reg_we: got %b want 1", reg_we); else n_pass++;
    n_total++; if (reg_idx !== 4'h1) $display("FAIL reg_idx: got %h want 1", reg_idx); else n_pass++;
    n_total++; if (reg_wdata !== 8'h22) $display("FAIL reg_wdata: got %h want 22", reg_wdata); else n_pass++;
    n_total++; if (vram_req !== 1'b0) $display("FAIL reg_no_vram: got %b want 0", vram_req); else n_pass++;
    step();
    n_total++; if (reg_we !== 1'b0) $display("FAIL reg_we_pulse: got %b want 0", reg_we); else n_pass++;
  endtask

  task automatic test_back_to_back();
    lat_mode = 2; lat_cnt = 2;
    pulse_cmd(16'h0040);
    pulse_dwr(8'hAA);
    n_total++; if ({vram_req, vram_we} !== 2'b11) $display("FAIL b2b_req: got %b want 11", {vram_req, vram_we}); else n_pass++;
    n_total++; if (vram_addr !== 14'h0000 || vram_wdata !== 8'hAA) $display("FAIL b2b_first: got %h/%h want 0000/aa", vram_addr, vram_wdata); else n_pass++;
    pulse_dwr(8'hBB);
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else n_pass++;
    wait_idle(); step();
    n_total++; if (mem[0] !== 8'hAA || mem[1] !== 8'hBB) $display("FAIL b2b_mem: got %h %h want aa bb", mem[0], mem[1]); else n_pass++;
    pulse_dwr(8'hCC);
    n_total++; if (vram_addr !== 14'h0002) $display("FAIL b2b_addr_end: got %h want 0002", vram_addr); else n_pass++;
    wait_idle();
    lat_mode = -1;
  endtask

  task automatic test_read();
    mem[14'h0034] = 8'h5A; mem[14'h0035] = 8'h6B;
    pulse_cmd(16'h3400);
    n_total++; if ({vram_req, vram_we} !== 2'b10 || vram_addr !== 14'h0034) $display("FAIL rd_req: got %b/%h want 10/0034", {vram_req, vram_we}, vram_addr); else n_pass++;
    wait_idle();
    n_total++; if (rd_buf !== 8'h5A) $display("FAIL rd_prefetch: got %h want 5a", rd_buf); else n_pass++;
    drd_valid = 1'b1;
    n_total++; if (rd_buf !== 8'h5A) $display("FAIL rd_return: got %h want 5a", rd_buf); else n_pass++;
    step(); drd_valid = 1'b0;
    wait_idle();
    n_total++; if (rd_buf !== 8'h6B) $display("FAIL rd_next: got %h want 6b", rd_buf); else n_pass++;
    pulse_dwr(8'h77);
    n_total++; if (vram_addr !== 14'h0036) $display("FAIL rd_addr_end: got %h want 0036", vram_addr); else n_pass++;
    wait_idle();
  endtask

  task automatic test_wrap();
    pulse_cmd(16'hFF7F);
    pulse_dwr(8'h01);
    n_total++; if (vram_addr !== 14'h3FFF) $display("FAIL wrap_first: got %h want 3fff", vram_addr); else n_pass++;
    wait_idle();
    pulse_dwr(8'h02);
    n_total++; if (vram_addr !== 14'h0000) $display("FAIL wrap_second: got %h want 0000", vram_addr); else n_pass++;
    wait_idle(); step();
    n_total++; if (mem[16383] !== 8'h01 || mem[0] !== 8'h02) $display("FAIL wrap_mem: got %h %h want 01 02", mem[16383], mem[0]); else n_pass++;
  endtask

  task automatic test_cram();
    pulse_cmd(16'h1FC0);
    pulse_dwr(8'h11);
    n_total++; if (cram_we !== 1'b1 || cram_addr !== 5'd31 || cram_wdata !== 8'h11) $display("FAIL cram_first: got %b/%0d/%h want 1/31/11", cram_we, cram_addr, cram_wdata); else n_pass++;
    n_total++; if (vram_req !== 1'b0 || busy !== 1'b0) $display("FAIL cram_no_vram: got %b/%b want 0/0", vram_req, busy); else n_pass++;
    pulse_dwr(8'h22);
    n_total++; if (cram_we !== 1'b1 || cram_addr !== 5'd0 || cram_wdata !== 8'h22) $display("FAIL cram_wrap: got %b/%0d/%h want 1/0/22", cram_we, cram_addr, cram_wdata); else n_pass++;
    step();
    n_total++; if (cram_we !== 1'b0) $display("FAIL cram_pulse: got %b want 0", cram_we); else n_pass++;
  endtask

  task automatic test_priority();
    logic [7:0] exp_drop;
`ifdef VDP_CMD_STATS_EN
    exp_drop = 8'd2;
`else
    exp_drop = 8'd0;
`endif
    do_reset();
    cmd_word = 16'h5582; dwr_byte = 8'h99;
    cmd_valid = 1'b1; dwr_valid = 1'b1; drd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; dwr_valid = 1'b0; drd_valid = 1'b0;
    n_total++; if (reg_we !== 1'b1 || reg_idx !== 4'h2 || reg_wdata !== 8'h55) $display("FAIL prio_cmd: got %b/%h/%h want 1/2/55", reg_we, reg_idx, reg_wdata); else n_pass++;
    n_total++; if (busy !== 1'b0 || rd_buf !== 8'h00) $display("FAIL prio_dropped: got busy=%b rd_buf=%h want 0/00", busy, rd_buf); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL prio_overrun: got %b want 1", overrun); else n_pass++;
    n_total++; if (drop_cnt !== exp_drop) $display("FAIL prio_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); else n_pass++;
    step();
  endtask

  task automatic test_overrun();
    logic [7:0] exp_drop;
`ifdef VDP_CMD_STATS_EN
    exp_drop = 8'd1;
`else
    exp_drop = 8'd0;
`endif
    do_reset();
    ack_hold = 1'b1;
    pulse_cmd(16'h0040);
    pulse_dwr(8'hA1); pulse_dwr(8'hA2); pulse_dwr(8'hA3);
    n_total++; if (vram_req !== 1'b1 || vram_wdata !== 8'hA1 || busy !== 1'b1) $display("FAIL ovr_inflight: got %b/%h/%b want 1/a1/1", vram_req, vram_wdata, busy); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else n_pass++;
    n_total++; if (drop_cnt !== exp_drop) $display("FAIL ovr_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); else n_pass++;
    reset_L = 1'b0; step(); reset_L = 1'b1;
    n_total++; if ({vram_req, busy, overrun} !== 3'b000 || drop_cnt !== 8'h00) $display("FAIL ovr_reset: got %b/%h want 000/00", {vram_req, busy, overrun}, drop_cnt); else n_pass++;
    force_ack = 1'b1; step(); force_ack = 1'b0; step();
    n_total++; if ({vram_req, busy} !== 2'b00 || rd_buf !== 8'h00) $display("FAIL stray_ack: got %b/%h want 00/00", {vram_req, busy}, rd_buf); else n_pass++;
    ack_hold = 1'b0;
  endtask

  task automatic test_random();
    logic [13:0] m_addr;
    logic [1:0]  m_code;
    logic [7:0]  m_rdbuf;
    logic [15:0] w;
    logic [7:0]  b;
    int          kind;
    int          bad;
    do_reset();
    lat_mode = -1;
    for (int i = 0; i < 16384; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < 32; i++) begin dut_cram[i] = 8'h00; m_cram[i] = 8'h00; end
    for (int i = 0; i < 16; i++) begin dut_regs[i] = 8'h00; m_regs[i] = 8'h00; end
    m_addr = 14'h0; m_code = 2'd0; m_rdbuf = 8'h00;
    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        w = 16'($urandom);
        pulse_cmd(w);
        m_code = w[7:6];
        m_addr = {w[5:0], w[15:8]};
        if (m_code == 2'd2) m_regs[w[3:0]] = w[15:8];
        if (m_code == 2'd0) begin m_rdbuf = ref_mem[m_addr]; m_addr = m_addr + 14'd1; end
      end else if (kind == 1) begin
        b = 8'($urandom);
        pulse_dwr(b);
        m_rdbuf = b;
        if (m_code == 2'd3) m_cram[m_addr[4:0]] = b;
        else ref_mem[m_addr] = b;
        m_addr = m_addr + 14'd1;
      end else begin
        drd_valid = 1'b1;
        n_total++; if (rd_buf !== m_rdbuf) $display("FAIL rand_drd_return[%0d]: got %h want %h", n, rd_buf, m_rdbuf); else n_pass++;
        step(); drd_valid = 1'b0;
        m_rdbuf = ref_mem[m_addr];
        m_addr = m_addr + 14'd1;
      end
      wait_idle(); step();
      n_total++; if (rd_buf !== m_rdbuf) $display("FAIL rand_rd_buf[%0d]: got %h want %h", n, rd_buf, m_rdbuf); else n_pass++;
    end
    bad = 0;
    for (int i = 0; i < 16384; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_total++; if (bad != 0) $display("FAIL rand_vram: got %0d differing bytes want 0", bad); else n_pass++;
    bad = 0;
    for (int i = 0; i < 32; i++) if (dut_cram[i] !== m_cram[i]) bad++;
    n_total++; if (bad != 0) $display("FAIL rand_cram: got %0d differing entries want 0", bad); else n_pass++;
    bad = 0;
    for (int i = 0; i < 16; i++) if (dut_regs[i] !== m_regs[i]) bad++;
    n_total++; if (bad != 0) $display("FAIL rand_regs: got %0d differing registers want 0", bad); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL rand_overrun: got %b want 0", overrun); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    test_reset();
    test_reg_write();
    test_back_to_back();
    test_read();
    test_wrap();
    test_cram();
    test_priority();
    test_overrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
